// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : Multiply/divide unit for the E stage, holding architectural
//             HI/LO. Multiplies register the full product and pad to
//             MUL_CYCLES. Divides run one restoring quotient bit per cycle,
//             then a sign-fix cycle, then pad to DIV_CYCLES. Also provides
//             multiply-accumulate/subtract, defined divide-by-zero and
//             MIN/-1 results, and launch gating by a pending interrupt (Req).
//  Ports    : clk        - clock, all state on posedge
//             reset      - asynchronous active-low reset, clears all state
//             SrcA/SrcB  - rs/rt operands (SrcA also carries mthi/mtlo data)
//             Start      - launch MDUOP (mult/div/madd family) this cycle
//             MDUOP      - 1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,
//                          7 madd,8 maddu,9 msub,10 msubu
//             ReadHILO   - 01 selects LO, 10 selects HI, else zero
//             Req        - pending interrupt/exception, blocks HI/LO changes
//             Busy       - operation in flight or being launched
//             MDUResult  - selected HI/LO, combinational from registers
//  Revision : 1.0  initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Start,
    input  logic [3:0]       MDUOP,
    input  logic [1:0]       ReadHILO,
    input  logic             Req,
    output logic             Busy,
    output logic [WIDTH-1:0] MDUResult
);

    localparam int CNT_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Counter value on the sign-fix edge: the WIDTH iteration edges come first.
    localparam logic [CNT_W-1:0] DIV_FIX_CNT = CNT_W'(DIV_CYCLES - WIDTH);

    generate
        if (DIV_CYCLES < WIDTH + 2) begin : g_div_cycles_check
            $error("mdu_iter: DIV_CYCLES must be at least WIDTH+2");
        end
        if (MUL_CYCLES < 1) begin : g_mul_cycles_check
            $error("mdu_iter: MUL_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [WIDTH-1:0]   hi, lo;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   quo, rem, dvs;
    logic               neg_q, neg_r, div_zero;

    logic               is_mul_op, is_div_op, launch_mul, launch_div, idle;
    logic               mul_signed, div_signed, a_neg, b_neg;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod_comb, mul_p, mul_res;
    logic [WIDTH:0]     trial, diff;
    logic               trial_ge;

    assign idle       = (state == S_IDLE);
    assign is_mul_op  = MDUOP inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10};
    assign is_div_op  = MDUOP inside {4'd3, 4'd4};
    assign launch_mul = idle & Start & ~Req & is_mul_op;
    assign launch_div = idle & Start & ~Req & is_div_op;
    assign Busy       = ~idle | (Start & ~Req);

    always_comb begin
        MDUResult = '0;
        if (ReadHILO == 2'b01)      MDUResult = lo;
        else if (ReadHILO == 2'b10) MDUResult = hi;
    end

    // Sign/zero extension to 2W bits makes the low 2W bits of the product
    // correct for both signed and unsigned operands.
    assign mul_signed = op_q inside {4'd1, 4'd7, 4'd9};
    assign ext_a      = mul_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    assign ext_b      = mul_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    assign prod_comb  = ext_a * ext_b;
    // With a single busy cycle the product register has not been loaded yet.
    assign mul_p      = (MUL_CYCLES == 1) ? prod_comb : prod_q;

    always_comb begin
        mul_res = mul_p;
        case (op_q)
            4'd7, 4'd8:  mul_res = {hi, lo} + mul_p;
            4'd9, 4'd10: mul_res = {hi, lo} - mul_p;
            default:     mul_res = mul_p;
        endcase
    end

    // Restoring step: the borrow bit of the trial subtraction decides the
    // quotient bit, since the partial remainder is always below the divisor.
    assign trial    = {rem, quo[WIDTH-1]};
    assign diff     = trial - {1'b0, dvs};
    assign trial_ge = ~diff[WIDTH];

    assign div_signed = (MDUOP == 4'd3);
    assign a_neg      = div_signed & SrcA[WIDTH-1];
    assign b_neg      = div_signed & SrcB[WIDTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            counter  <= '0;
            hi       <= '0;
            lo       <= '0;
            op_q     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            prod_q   <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch_mul) begin
                        op_q    <= MDUOP;
                        op_a    <= SrcA;
                        op_b    <= SrcB;
                        counter <= CNT_W'(MUL_CYCLES);
                        state   <= S_MUL;
                    end else if (launch_div) begin
                        op_q     <= MDUOP;
                        op_a     <= SrcA;
                        op_b     <= SrcB;
                        quo      <= a_neg ? -SrcA : SrcA;
                        dvs      <= b_neg ? -SrcB : SrcB;
                        rem      <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (SrcB == '0);
                        counter  <= CNT_W'(DIV_CYCLES);
                        state    <= S_DIV;
                    end else if (!Req && MDUOP == 4'd5) begin
                        hi <= SrcA;
                    end else if (!Req && MDUOP == 4'd6) begin
                        lo <= SrcA;
                    end
                end
                S_MUL: begin
                    prod_q  <= prod_comb;
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        {hi, lo} <= mul_res;
                        state    <= S_IDLE;
                    end
                end
                S_DIV: begin
                    counter <= counter - CNT_W'(1);
                    if (counter > DIV_FIX_CNT) begin
                        quo <= {quo[WIDTH-2:0], trial_ge};
                        rem <= trial_ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                    end else if (counter == DIV_FIX_CNT) begin
                        if (neg_q) quo <= -quo;
                        if (neg_r) rem <= -rem;
                    end
                    if (counter == CNT_W'(1)) begin
                        // Divide by zero returns all-ones quotient and the
                        // dividend as remainder; MIN/-1 falls out naturally.
                        hi    <= div_zero ? op_a : rem;
                        lo    <= div_zero ? '1 : quo;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_iter
//  Purpose  : Self-checking bench for mdu_iter (WIDTH=32). A behavioural
//             model computes HI/LO with plain 64-bit arithmetic and tracks the
//             busy window; a compare process checks Busy/MDUResult every
//             cycle, and directed operations check literal results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdu_iter;
    localparam int W    = 32;
    localparam int MULC = 5;
    localparam int DIVC = 34;

    logic         clk, reset, Start, Req;
    logic [W-1:0] SrcA, SrcB, MDUResult;
    logic [3:0]   MDUOP;
    logic [1:0]   ReadHILO;
    logic         Busy;

    int n_checks = 0;
    int n_errors = 0;

    mdu_iter #(.WIDTH(W), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .Start(Start),
        .MDUOP(MDUOP), .ReadHILO(ReadHILO), .Req(Req), .Busy(Busy),
        .MDUResult(MDUResult)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one operation, straight from the op definitions.
    function automatic logic [63:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] h,
                                              input logic [31:0] l);
        longint sp;
        logic [63:0] up, acc;
        int sa, sb;
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = {32'd0, a} * {32'd0, b};
        acc = {h, l};
        sa  = $signed(a);
        sb  = $signed(b);
        case (op)
            4'd1:  return sp;
            4'd2:  return up;
            4'd7:  return acc + sp;
            4'd8:  return acc + up;
            4'd9:  return acc - sp;
            4'd10: return acc - up;
            4'd3: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd4: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return acc;
        endcase
    endfunction

    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic [3:0]  m_op = '0;
    int          m_rem = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi  <= '0;
            m_lo  <= '0;
            m_rem <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) {m_hi, m_lo} <= model_res(m_op, m_a, m_b, m_hi, m_lo);
        end else if (Start && !Req && (MDUOP inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10})) begin
            m_rem <= (MDUOP inside {4'd3, 4'd4}) ? DIVC : MULC;
            m_op  <= MDUOP;
            m_a   <= SrcA;
            m_b   <= SrcB;
        end else if (!Req && MDUOP == 4'd5) begin
            m_hi <= SrcA;
        end else if (!Req && MDUOP == 4'd6) begin
            m_lo <= SrcA;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("cyc busy", Busy, (m_rem != 0) || (Start && !Req));
            chk("cyc result", MDUResult,
                (ReadHILO == 2'b01) ? m_lo : (ReadHILO == 2'b10) ? m_hi : 32'd0);
        end
    end

    // Launch an op, count Busy cycles, optionally pulse Req or assert reset.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy, input int req_at, input int rst_at,
                          input string name);
        int cnt;
        bit done;
        cnt  = 0;
        done = 0;
        @(posedge clk); #1;
        SrcA = a; SrcB = b; MDUOP = op; Start = 1'b1;
        @(negedge clk);
        if (Busy) cnt++;
        @(posedge clk); #1;
        Start = 1'b0; MDUOP = 4'd0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!Busy) begin
                done = 1;
            end else begin
                cnt++;
                if (req_at > 0 && cnt == req_at) Req = 1'b1;
                if (req_at > 0 && cnt == req_at + 2) Req = 1'b0;
                if (rst_at > 0 && cnt == rst_at) begin
                    reset = 1'b0;
                    #1 chk({name, " rst busy"}, Busy, 0);
                    ReadHILO = 2'b10;
                    #1 chk({name, " rst hi"}, MDUResult, 0);
                    ReadHILO = 2'b01;
                    #1 chk({name, " rst lo"}, MDUResult, 0);
                    done = 1;
                end
            end
        end
        chk({name, " completed"}, done, 1);
        if (exp_busy > 0) chk({name, " busy cycles"}, cnt, exp_busy);
    endtask

    task automatic check_hl(input logic [31:0] eh, input logic [31:0] el, input string name);
        @(posedge clk); #1 ReadHILO = 2'b10;
        @(negedge clk);
        chk({name, " HI"}, MDUResult, eh);
        chk({name, " model HI"}, m_hi, eh);
        @(posedge clk); #1 ReadHILO = 2'b01;
        @(negedge clk);
        chk({name, " LO"}, MDUResult, el);
        chk({name, " model LO"}, m_lo, el);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        @(posedge clk); #1;
        SrcA = a; MDUOP = op;
        @(posedge clk); #1;
        MDUOP = 4'd0;
    endtask

    initial begin
        reset = 1'b0; Start = 1'b0; Req = 1'b0;
        SrcA = '0; SrcB = '0; MDUOP = 4'd0; ReadHILO = 2'b01;
        repeat (2) @(negedge clk);
        chk("reset busy", Busy, 0);
        chk("reset lo", MDUResult, 0);
        ReadHILO = 2'b10;
        #1 chk("reset hi", MDUResult, 0);
        ReadHILO = 2'b01;
        @(posedge clk); #2 reset = 1'b1;

        // T1 and plain multiplies
        run_op(4'd1, 32'hFFFFFFFD, 32'd5, 6, 0, 0, "mult -3*5");
        check_hl(32'hFFFFFFFF, 32'hFFFFFFF1, "mult -3*5");
        run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, 0, 0, "multu max");
        check_hl(32'hFFFFFFFE, 32'h00000001, "multu max");

        // T2 divides
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 35, 0, 0, "div -7/2");
        check_hl(32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
        run_op(4'd4, 32'd7, 32'd2, 35, 0, 0, "divu 7/2");
        check_hl(32'd1, 32'd3, "divu 7/2");

        // T3 divide corner cases
        run_op(4'd4, 32'h10, 32'd0, 35, 0, 0, "divu 10/0");
        check_hl(32'h10, 32'hFFFFFFFF, "divu 10/0");
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 35, 0, 0, "div min/-1");
        check_hl(32'd0, 32'h80000000, "div min/-1");
        run_op(4'd3, 32'hFFFFFFFB, 32'd0, 35, 0, 0, "div -5/0");
        check_hl(32'hFFFFFFFB, 32'hFFFFFFFF, "div -5/0");

        // Signed accumulate family
        mt(4'd6, 32'd10);
        mt(4'd5, 32'd0);
        run_op(4'd7, 32'hFFFFFFFE, 32'd3, 6, 0, 0, "madd -2*3");
        check_hl(32'd0, 32'd4, "madd -2*3");
        run_op(4'd10, 32'd2, 32'd3, 6, 0, 0, "msubu 2*3");
        check_hl(32'hFFFFFFFF, 32'hFFFFFFFE, "msubu 2*3");

        // T4 carry/borrow across the HI/LO boundary
        mt(4'd6, 32'hFFFFFFFF);
        mt(4'd5, 32'd0);
        run_op(4'd8, 32'd1, 32'd1, 6, 0, 0, "maddu 1*1");
        check_hl(32'd1, 32'd0, "maddu 1*1");
        run_op(4'd9, 32'd1, 32'd1, 6, 0, 0, "msub 1*1");
        check_hl(32'd0, 32'hFFFFFFFF, "msub 1*1");

        // T5 Req blocks launches and mthi, but not a running divide
        @(posedge clk); #1;
        Req = 1'b1; Start = 1'b1; MDUOP = 4'd1; SrcA = 32'd3; SrcB = 32'd3;
        @(negedge clk);
        chk("req start busy", Busy, 0);
        @(posedge clk); #1;
        Start = 1'b0; MDUOP = 4'd5; SrcA = 32'h1234;
        @(posedge clk); #1;
        Req = 1'b0; MDUOP = 4'd0;
        check_hl(32'd0, 32'hFFFFFFFF, "req blocked");
        run_op(4'd3, 32'd100, 32'd7, 35, 5, 0, "div req pulse");
        check_hl(32'd2, 32'd14, "div req pulse");

        @(posedge clk); #1 ReadHILO = 2'b00;
        @(negedge clk);
        chk("readhilo 00", MDUResult, 0);
        @(posedge clk); #1 ReadHILO = 2'b01;

        // T6 async reset mid-divide, then a fresh multiply
        run_op(4'd3, 32'd1000, 32'd3, 0, 0, 10, "div reset");
        @(posedge clk); #2 reset = 1'b1;
        check_hl(32'd0, 32'd0, "after reset");
        run_op(4'd1, 32'd7, 32'd6, 6, 0, 0, "mult 7*6");
        check_hl(32'd0, 32'd42, "mult 7*6");

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
